// File: rtl/halut_pkg.sv
// ============================================================================
// Module      : halut_pkg
// Description : Shared types and constants for the HALUT matmul control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package halut_pkg;

   localparam int unsigned c_default_drain_cycles = 8;

   typedef enum logic [1:0] {
      OP_LOAD_ENC = 2'd0,
      OP_LOAD_DEC = 2'd1,
      OP_RUN      = 2'd2,
      OP_RSVD     = 2'd3
   } ctrl_op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_ENC = 3'd1,
      ST_LOAD_DEC = 3'd2,
      ST_RUN      = 3'd3,
      ST_DRAIN    = 3'd4
   } ctrl_state_e;

   // Width of an index over n items, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/halut_cfg_addr_gen.sv
// ============================================================================
// Module      : halut_cfg_addr_gen
// Description : Nested outer/inner counter walking a config word stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halut_cfg_addr_gen #(
   parameter int unsigned OUTER_N = 4,
   parameter int unsigned INNER_N = 128,
   parameter int unsigned OUTER_W = 2,
   parameter int unsigned INNER_W = 7
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               step_i,
   output logic [OUTER_W-1:0] outer_o,
   output logic [INNER_W-1:0] inner_o,
   output logic               last_o
);

   localparam logic [OUTER_W-1:0] c_outer_max = OUTER_W'(OUTER_N - 1);
   localparam logic [INNER_W-1:0] c_inner_max = INNER_W'(INNER_N - 1);

   logic [OUTER_W-1:0] r_outer;
   logic [INNER_W-1:0] r_inner;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_outer <= '0;
         r_inner <= '0;
      end else if (step_i) begin
         if (r_inner == c_inner_max) begin
            r_inner <= '0;
            r_outer <= (r_outer == c_outer_max) ? '0 : r_outer + 1'b1;
         end else begin
            r_inner <= r_inner + 1'b1;
         end
      end
   end

   assign outer_o = r_outer;
   assign inner_o = r_inner;
   assign last_o  = (r_outer == c_outer_max) && (r_inner == c_inner_max);

endmodule

`default_nettype wire

// File: rtl/halut_matmul_ctrl.sv
// ============================================================================
// Module      : halut_matmul_ctrl
// Description : Command sequencer driving HALUT core config writes and runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halut_matmul_ctrl
   import halut_pkg::*;
#(
   parameter int unsigned K             = 16,
   parameter int unsigned C             = 32,
   parameter int unsigned M             = 32,
   parameter int unsigned DataTypeWidth = 16,
   parameter int unsigned DecoderUnits  = 16,
   parameter int unsigned EncUnits      = 4,
   parameter int unsigned RunLenWidth   = 16,
   parameter int unsigned DrainCycles   = c_default_drain_cycles,
   localparam int unsigned DecUnitsX          = M / DecoderUnits,
   localparam int unsigned TotalAddrWidth     = $clog2(C * K),
   localparam int unsigned DecAddrWidth       = $clog2(DecoderUnits),
   localparam int unsigned ThreshMemAddrWidth = $clog2((C / EncUnits) * K)
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        cmd_valid_i,
   output logic                                        cmd_ready_o,
   input  logic [1:0]                                  cmd_op_i,
   input  logic [RunLenWidth-1:0]                      cmd_len_i,
   input  logic                                        wvalid_i,
   output logic                                        wready_o,
   input  logic [DataTypeWidth-1:0]                    wdata_i,
   output logic [EncUnits-1:0][ThreshMemAddrWidth-1:0] waddr_enc_o,
   output logic [EncUnits-1:0][DataTypeWidth-1:0]      wdata_enc_o,
   output logic [EncUnits-1:0]                         we_enc_o,
   output logic [DecUnitsX-1:0][DecAddrWidth-1:0]      m_addr_dec_o,
   output logic [DecUnitsX-1:0][TotalAddrWidth-1:0]    waddr_dec_o,
   output logic [DecUnitsX-1:0][DataTypeWidth-1:0]     wdata_dec_o,
   output logic [DecUnitsX-1:0]                        we_dec_o,
   output logic                                        encoder_o,
   input  logic [DecUnitsX-1:0]                        dec_valid_i,
   output logic                                        busy_o,
   output logic                                        done_o,
   output logic                                        err_o,
   output logic [RunLenWidth-1:0]                      result_cnt_o
);

   localparam int unsigned c_enc_outer_w = clog2_min1(EncUnits);
   localparam int unsigned c_dec_outer_w = clog2_min1(M);
   localparam int unsigned c_dec_x_w     = clog2_min1(DecUnitsX);
   localparam int unsigned c_drain_w     = clog2_min1(DrainCycles + 1);

   ctrl_state_e r_state;

   logic [EncUnits-1:0][ThreshMemAddrWidth-1:0] r_waddr_enc;
   logic [EncUnits-1:0][DataTypeWidth-1:0]      r_wdata_enc;
   logic [EncUnits-1:0]                         r_we_enc;
   logic [DecUnitsX-1:0][DecAddrWidth-1:0]      r_m_addr_dec;
   logic [DecUnitsX-1:0][TotalAddrWidth-1:0]    r_waddr_dec;
   logic [DecUnitsX-1:0][DataTypeWidth-1:0]     r_wdata_dec;
   logic [DecUnitsX-1:0]                        r_we_dec;
   logic                                        r_encoder;
   logic                                        r_done;
   logic                                        r_err;
   logic [RunLenWidth-1:0]                      r_result_cnt;
   logic [RunLenWidth-1:0]                      r_run_left;
   logic [c_drain_w-1:0]                        r_idle_cnt;

   logic [c_enc_outer_w-1:0]      w_enc_unit;
   logic [ThreshMemAddrWidth-1:0] w_enc_addr;
   logic                          w_enc_last;
   logic [c_dec_outer_w-1:0]      w_dec_outer;
   logic [TotalAddrWidth-1:0]     w_dec_addr;
   logic                          w_dec_last;
   logic [c_dec_x_w-1:0]          w_dec_x;
   logic [DecAddrWidth-1:0]       w_dec_m;
   logic                          w_unused_dec_valid;

   halut_cfg_addr_gen #(
      .OUTER_N (EncUnits),
      .INNER_N ((C / EncUnits) * K),
      .OUTER_W (c_enc_outer_w),
      .INNER_W (ThreshMemAddrWidth)
   ) u_enc_addr_gen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (r_state == ST_IDLE),
      .step_i  (wvalid_i && (r_state == ST_LOAD_ENC)),
      .outer_o (w_enc_unit),
      .inner_o (w_enc_addr),
      .last_o  (w_enc_last)
   );

   // Decoder stream counts output columns outermost; x and m are split from it.
   halut_cfg_addr_gen #(
      .OUTER_N (M),
      .INNER_N (C * K),
      .OUTER_W (c_dec_outer_w),
      .INNER_W (TotalAddrWidth)
   ) u_dec_addr_gen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (r_state == ST_IDLE),
      .step_i  (wvalid_i && (r_state == ST_LOAD_DEC)),
      .outer_o (w_dec_outer),
      .inner_o (w_dec_addr),
      .last_o  (w_dec_last)
   );

   assign w_dec_x = c_dec_x_w'(32'(w_dec_outer) / DecoderUnits);
   assign w_dec_m = DecAddrWidth'(32'(w_dec_outer) % DecoderUnits);

   // Only decoder column 0 is counted; the other valids are observed but unused.
   assign w_unused_dec_valid = ^dec_valid_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_waddr_enc  <= '0;
         r_wdata_enc  <= '0;
         r_we_enc     <= '0;
         r_m_addr_dec <= '0;
         r_waddr_dec  <= '0;
         r_wdata_dec  <= '0;
         r_we_dec     <= '0;
         r_encoder    <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_result_cnt <= '0;
         r_run_left   <= '0;
         r_idle_cnt   <= '0;
      end else begin
         r_we_enc <= '0;
         r_we_dec <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  case (ctrl_op_e'(cmd_op_i))
                     OP_LOAD_ENC: r_state <= ST_LOAD_ENC;
                     OP_LOAD_DEC: r_state <= ST_LOAD_DEC;
                     OP_RUN: begin
                        r_result_cnt <= '0;
                        r_idle_cnt   <= '0;
                        r_run_left   <= cmd_len_i;
                        if (cmd_len_i == '0) begin
                           r_state <= ST_DRAIN;
                        end else begin
                           r_state   <= ST_RUN;
                           r_encoder <= 1'b1;
                        end
                     end
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            ST_LOAD_ENC: begin
               if (wvalid_i) begin
                  r_we_enc                <= EncUnits'(1) << w_enc_unit;
                  r_waddr_enc[w_enc_unit] <= w_enc_addr;
                  r_wdata_enc[w_enc_unit] <= wdata_i;
                  if (w_enc_last) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_LOAD_DEC: begin
               if (wvalid_i) begin
                  r_we_dec              <= DecUnitsX'(1) << w_dec_x;
                  r_m_addr_dec[w_dec_x] <= w_dec_m;
                  r_waddr_dec[w_dec_x]  <= w_dec_addr;
                  r_wdata_dec[w_dec_x]  <= wdata_i;
                  if (w_dec_last) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (dec_valid_i[0] && (r_result_cnt != '1)) r_result_cnt <= r_result_cnt + 1'b1;
               r_run_left <= r_run_left - 1'b1;
               if (r_run_left == RunLenWidth'(1)) begin
                  r_encoder <= 1'b0;
                  r_state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (dec_valid_i[0] && (r_result_cnt != '1)) r_result_cnt <= r_result_cnt + 1'b1;
               if (dec_valid_i[0]) begin
                  r_idle_cnt <= '0;
               end else if (r_idle_cnt == c_drain_w'(DrainCycles - 1)) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o  = (r_state == ST_IDLE);
   assign wready_o     = (r_state == ST_LOAD_ENC) || (r_state == ST_LOAD_DEC);
   assign busy_o       = (r_state != ST_IDLE);
   assign waddr_enc_o  = r_waddr_enc;
   assign wdata_enc_o  = r_wdata_enc;
   assign we_enc_o     = r_we_enc;
   assign m_addr_dec_o = r_m_addr_dec;
   assign waddr_dec_o  = r_waddr_dec;
   assign wdata_dec_o  = r_wdata_dec;
   assign we_dec_o     = r_we_dec;
   assign encoder_o    = r_encoder;
   assign done_o       = r_done;
   assign err_o        = r_err;
   assign result_cnt_o = r_result_cnt;

endmodule

`default_nettype wire

// File: tb/tb_halut_matmul_ctrl.sv
// ============================================================================
// Module      : tb_halut_matmul_ctrl
// Description : Self-checking bench for the HALUT matmul command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_halut_matmul_ctrl;

   localparam int K = 16, C = 32, M = 32, DW = 16, DU = 16, EU = 4, RLW = 16;
   localparam int DUX = 2, TAW = 9, DAW = 4, TMAW = 7;
   localparam int N_ENC = C * K;
   localparam int N_DEC = M * C * K;
   localparam int ENC_PER_UNIT = (C / EU) * K;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     cmd_valid, cmd_ready;
   logic [1:0]               cmd_op;
   logic [RLW-1:0]           cmd_len;
   logic                     wvalid, wready;
   logic [DW-1:0]            wdata;
   logic [EU-1:0][TMAW-1:0]  waddr_enc;
   logic [EU-1:0][DW-1:0]    wdata_enc;
   logic [EU-1:0]            we_enc;
   logic [DUX-1:0][DAW-1:0]  m_addr_dec;
   logic [DUX-1:0][TAW-1:0]  waddr_dec;
   logic [DUX-1:0][DW-1:0]   wdata_dec;
   logic [DUX-1:0]           we_dec;
   logic                     encoder;
   logic [DUX-1:0]           dec_valid;
   logic                     busy, done, err;
   logic [RLW-1:0]           result_cnt;

   always #5 clk = ~clk;

   halut_matmul_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_op_i     (cmd_op),
      .cmd_len_i    (cmd_len),
      .wvalid_i     (wvalid),
      .wready_o     (wready),
      .wdata_i      (wdata),
      .waddr_enc_o  (waddr_enc),
      .wdata_enc_o  (wdata_enc),
      .we_enc_o     (we_enc),
      .m_addr_dec_o (m_addr_dec),
      .waddr_dec_o  (waddr_dec),
      .wdata_dec_o  (wdata_dec),
      .we_dec_o     (we_dec),
      .encoder_o    (encoder),
      .dec_valid_i  (dec_valid),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .result_cnt_o (result_cnt)
   );

   int n_pass = 0;
   int n_chk  = 0;
   bit dv [256];

   typedef struct {
      logic [1:0]  op;
      int          len;
      logic [31:0] mask;
      int          f;
      int          cnt;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_write(input bit is_dec, input int n, input logic [DW-1:0] d, input bit last);
      if (!is_dec) begin
         int u = n / ENC_PER_UNIT;
         int a = n % ENC_PER_UNIT;
         chk("enc_we", {we_enc, we_dec}, longint'(1) << (DUX + u));
         chk("enc_waddr", waddr_enc[u], a);
         chk("enc_wdata", wdata_enc[u], d);
      end else begin
         int x = n / (DU * C * K);
         int m = (n / (C * K)) % DU;
         int a = n % (C * K);
         chk("dec_we", {we_enc, we_dec}, longint'(1) << x);
         chk("dec_maddr", m_addr_dec[x], m);
         chk("dec_waddr", waddr_dec[x], a);
         chk("dec_wdata", wdata_dec[x], d);
      end
      chk("load_done", done, last);
   endtask

   // mode 0: no gaps, data=n; mode 1: alternate valid; mode 2: random gaps and stray commands
   task automatic do_load(input bit is_dec, input int mode, input int max_words, output int writes);
      int total, n, cyc;
      bit acc, saw_err;
      logic [DW-1:0] d;
      total = is_dec ? N_DEC : N_ENC;
      cmd_op = is_dec ? 2'd1 : 2'd0;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("load_busy", busy, 1);
      n = 0; writes = 0; saw_err = 0; cyc = 0;
      while (n < total && n < max_words && cyc < 4 * total + 16) begin
         case (mode)
            0: wvalid = 1'b1;
            1: wvalid = (cyc % 2 == 0);
            default: wvalid = 1'($urandom_range(0, 1));
         endcase
         d = (mode == 0) ? DW'(n) : DW'($urandom);
         wdata = d;
         if (mode == 2) begin
            cmd_valid = 1'b1;
            cmd_op = 2'd3;
         end
         acc = wvalid && wready;
         step();
         if (err) saw_err = 1;
         if (acc) begin
            check_write(is_dec, n, d, n == total - 1);
            n++;
            writes++;
         end else begin
            chk("gap_no_write", {we_enc, we_dec}, 0);
         end
         cyc++;
      end
      wvalid = 1'b0;
      cmd_valid = 1'b0;
      chk("load_words_accepted", n, (max_words < total) ? max_words : total);
      chk("no_err_in_load", saw_err, 0);
   endtask

   task automatic do_run(input logic [1:0] op, input int len, input int f_exp, input int cnt_exp);
      int enc_cnt, enc_first, enc_last, done_t, done_n, err_n, limit;
      bit busy_bad;
      cmd_op = op;
      cmd_len = RLW'(len);
      cmd_valid = 1'b1;
      dec_valid = '0;
      step();
      cmd_valid = 1'b0;
      enc_cnt = 0; enc_first = -1; enc_last = -1;
      done_t = -1; done_n = 0; err_n = 0; busy_bad = 0;
      limit = (op == 2'd3) ? 4 : f_exp + 4;
      for (int t = 0; t < limit; t++) begin
         if (encoder) begin
            enc_cnt++;
            if (enc_first < 0) enc_first = t;
            enc_last = t;
         end
         if (done) begin
            done_n++;
            if (done_t < 0) done_t = t;
         end
         if (err) err_n++;
         if (op == 2'd3) begin
            if (busy) busy_bad = 1;
         end else if (t < f_exp && !busy) begin
            busy_bad = 1;
         end else if (t >= f_exp && busy) begin
            busy_bad = 1;
         end
         dec_valid[0] = (t + 1 < 256) ? dv[t + 1] : 1'b0;
         dec_valid[1] = 1'($urandom_range(0, 1));
         step();
      end
      dec_valid = '0;
      chk("run_busy_profile", busy_bad, 0);
      if (op == 2'd3) begin
         chk("rsvd_err_pulses", err_n, 1);
         chk("rsvd_no_done", done_n, 0);
         chk("rsvd_no_encoder", enc_cnt, 0);
      end else begin
         chk("run_enc_cycles", enc_cnt, len);
         chk("run_enc_first", enc_first, (len > 0) ? 0 : -1);
         chk("run_enc_last", enc_last, len - 1);
         chk("run_done_time", done_t, f_exp);
         chk("run_done_pulses", done_n, 1);
         chk("run_result_cnt", result_cnt, cnt_exp);
         chk("run_no_err", err_n, 0);
      end
   endtask

   // Done comes on the 8th consecutive valid-free cycle once encoding has ended.
   task automatic model(input int len, output int f, output int cnt);
      int idle;
      idle = 0; f = -1; cnt = 0;
      for (int e = 1; e < 256 && f < 0; e++) begin
         if (dv[e]) cnt++;
         if (e >= len + 1) begin
            if (dv[e]) idle = 0;
            else begin
               idle++;
               if (idle == 8) f = e;
            end
         end
      end
   endtask

   initial begin
      int w, f, cnt, len;
      tbl[0] = '{op: 2'd3, len: 0, mask: 32'h0,   f: 0,  cnt: 0};
      tbl[1] = '{op: 2'd2, len: 5, mask: 32'h54,  f: 14, cnt: 3};
      tbl[2] = '{op: 2'd2, len: 0, mask: 32'h0,   f: 8,  cnt: 0};
      tbl[3] = '{op: 2'd2, len: 2, mask: 32'h22,  f: 13, cnt: 2};
      tbl[4] = '{op: 2'd2, len: 3, mask: 32'h230, f: 17, cnt: 3};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
      wvalid = 1'b0; wdata = '0; dec_valid = '0;
      step();
      step();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", {we_enc, we_dec}, 0);
      chk("rst_encoder", encoder, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_result_cnt", result_cnt, 0);
      chk("rst_waddr_enc", waddr_enc, 0);
      rst = 1'b0;
      step();

      do_load(0, 0, N_ENC, w);
      chk("enc_writes", w, N_ENC);
      chk("enc_idle_after", {busy, wready}, 0);
      do_load(0, 1, N_ENC, w);
      chk("enc_gap_writes", w, N_ENC);

      do_load(1, 2, 100, w);
      rst = 1'b1;
      step();
      step();
      chk("midrst_we", {we_enc, we_dec}, 0);
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_waddr_dec", waddr_dec, 0);
      rst = 1'b0;
      step();
      chk("midrst_still_idle", {busy, cmd_ready}, 1);

      do_load(1, 0, N_DEC, w);
      chk("dec_writes", w, N_DEC);
      chk("dec_idle_after", busy, 0);

      foreach (tbl[i]) begin
         for (int e = 0; e < 256; e++) dv[e] = (e < 32) ? tbl[i].mask[e] : 1'b0;
         do_run(tbl[i].op, tbl[i].len, tbl[i].f, tbl[i].cnt);
         step();
      end

      for (int r = 0; r < 12; r++) begin
         len = $urandom_range(0, 20);
         for (int e = 0; e < 256; e++)
            dv[e] = (e >= 1 && e <= len + 30) ? ($urandom_range(0, 3) == 0) : 1'b0;
         model(len, f, cnt);
         for (int e = f + 1; e < 256; e++) dv[e] = 1'b0;
         do_run(2'd2, len, f, cnt);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/halut_matmul_ctrl.md
Name: halut_matmul_ctrl

Overview:
Sequencer in front of the HALUT matmul core. Takes simple commands (load encoder thresholds, load decoder LUTs, run) over a valid/ready interface and drives the core's write-port arrays and encoder enable. A single serial config word stream is unpacked into per-unit writes. It counts decoder results and signals completion. Sits between the host/DMA shim and the matmul top level.

Parameters:
K, 16, prototypes per codebook
C, 32, codebooks
M, 32, output columns
DataTypeWidth, 16, config word width
DecoderUnits, 16, decoder units per decoder column
EncUnits, 4, encoder units
RunLenWidth, 16, width of run length / result counter
DrainCycles, 8, idle cycles with no decoder valid before a run is done
Derived, not overridable: DecUnitsX=M/DecoderUnits, TotalAddrWidth=clog2(C*K), DecAddrWidth=clog2(DecoderUnits), ThreshMemAddrWidth=clog2((C/EncUnits)*K)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  high only in IDLE
cmd_op_i  in  2  0=LOAD_ENC, 1=LOAD_DEC, 2=RUN, 3=reserved
cmd_len_i  in  RunLenWidth  RUN: encoder-enable cycles; ignored otherwise
wvalid_i  in  1  config word valid
wready_o  out  1  high only in LOAD_ENC/LOAD_DEC
wdata_i  in  DataTypeWidth  config word
waddr_enc_o, wdata_enc_o, we_enc_o  out  [EncUnits] x (ThreshMemAddrWidth, DataTypeWidth, 1)  encoder threshold write ports
m_addr_dec_o, waddr_dec_o, wdata_dec_o, we_dec_o  out  [DecUnitsX] x (DecAddrWidth, TotalAddrWidth, DataTypeWidth, 1)  decoder LUT write ports
encoder_o  out  1  encoder enable to core
dec_valid_i  in  [DecUnitsX] x 1  core decoder valid outputs
busy_o  out  1  not IDLE
done_o  out  1  one-cycle pulse at end of any command
err_o  out  1  one-cycle pulse on reserved op
result_cnt_o  out  RunLenWidth  decoder-0 valids seen in last/current RUN

Behaviour:
- Reset (sync, rst_i=1 at posedge): state IDLE, all we_* 0, all addr/data outputs 0, encoder_o 0, done_o/err_o 0, result_cnt_o 0, internal counters 0. Reset mid-command aborts it; partial writes are not undone.
- FSM states: IDLE, LOAD_ENC, LOAD_DEC, RUN, DRAIN.
- IDLE: cmd_ready_o=1. On cmd_valid_i: op0->LOAD_ENC, op1->LOAD_DEC, op2->RUN (cmd_len_i latched, result_cnt_o cleared), op3->err_o pulse next cycle, stay IDLE. RUN with len=0 goes directly to DRAIN.
- LOAD_ENC: word accepted when wvalid_i&&wready_o. Word n (0..C*K-1): unit=n/((C/EncUnits)*K), addr=n mod that. Next cycle: we_enc_o[unit]=1 (one-hot), waddr/wdata set; all other we 0. After the last word (n=C*K-1) accepted: -> IDLE, done_o pulses with the final write cycle.
- LOAD_DEC: word n (0..M*C*K-1): x=n/(DecoderUnits*C*K), m=(n/(C*K)) mod DecoderUnits, addr=n mod (C*K). Registered one cycle as above; we_dec_o one-hot over x. Last word -> IDLE, done_o pulse.
- Write outputs are registered: exactly one write per accepted word, latency 1. Input gaps (wvalid_i=0) produce no write; we_* stay 0.
- RUN: encoder_o=1 for exactly cmd_len_i consecutive cycles, starting the cycle after acceptance, then -> DRAIN with encoder_o=0.
- DRAIN: idle counter reset on any dec_valid_i[0]; when it reaches DrainCycles -> IDLE, done_o pulse.
- result_cnt_o increments on each dec_valid_i[0] in RUN or DRAIN; it saturates at all-ones. Other dec_valid_i bits are ignored for counting.
- The command is not accepted while busy; cmd_valid_i is ignored outside IDLE.

Decomposition:
- halut_pkg additions: ctrl_op_e enum (LOAD_ENC, LOAD_DEC, RUN, RSVD), ctrl_state_e, default DrainCycles constant.
- One sub-module: halut_cfg_addr_gen. It is a nested counter (outer index, inner address) with a last-flag, instantiated twice for the encoder and decoder split.

Test Plan:
- Reset: assert rst_i for 2 cycles mid-LOAD_DEC -> next cycle IDLE, all we 0, cmd_ready_o=1, busy_o=0.
- LOAD_ENC, 512 words value=n, no gaps -> word 128 writes we_enc_o[1], waddr=0, data=128. Word 511 writes unit 3, addr 127, with a done_o pulse on that cycle.
- LOAD_ENC with wvalid_i toggling every other cycle -> exactly 512 writes and no write during gaps. The address sequence matches the gap-free case.
- LOAD_DEC, 16384 words -> word 512: x=0, m=1, addr=0. Word 8192: x=1, m=0, addr=0. One done_o after word 16383.
- RUN len=5, model drives 3 dec_valid_i[0] pulses -> encoder_o high exactly 5 cycles, result_cnt_o=3. done_o comes 8 cycles after the last valid.
- op=3 -> err_o pulses once, busy_o stays 0. RUN len=0 -> encoder_o never high, done_o after 8 cycles.
